// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Parity bit is present only when UART_TX_PARITY_EN is defined.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       parity_in,
  input  logic       load,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity;
  assign unused_parity = parity_in;
`endif

  assign bit_end = (cnt_q == BIT_END);
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Outputs are computed one cycle ahead so tx/busy/done come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (load) begin
          state_d = START;
          data_d  = data_in;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = parity_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer at CLKS_PER_BIT=4; frame length follows UART_TX_PARITY_EN.
module tb_uart_tx_framer;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       parity_in = 1'b0;
  logic       load = 1'b0;
  logic       tx, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] sb_q[$];
  int exp_done_total = 0;
  int done_cnt = 0;

  uart_tx_framer #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
    .load(load), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {1'b1, 1'b1, d, 1'b0};
`endif
  endfunction

  // Monitor: detects a start edge, then checks every cycle of every bit and the done cycle.
  logic        mon_act = 1'b0;
  logic        prev_tx = 1'b1;
  logic [10:0] cur;
  logic [C-1:0] smp;
  int mcyc, busy_cnt, ncyc, last_done_ncyc, last_gap;
  logic early_done;

  initial begin
    ncyc = 0; last_done_ncyc = 0; last_gap = -1;
    mcyc = 0; busy_cnt = 0; early_done = 1'b0; smp = '0; cur = '0;
  end

  always @(negedge clk) begin
    ncyc++;
    if (done && rst) done_cnt++;
    if (!rst) begin
      mon_act = 1'b0;
    end else if (!mon_act && prev_tx && !tx) begin
      check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        cur = sb_q.pop_front();
        mon_act = 1'b1;
        mcyc = 0; busy_cnt = 0; early_done = 1'b0; smp = '0;
        last_gap = ncyc - last_done_ncyc;
      end
    end
    if (mon_act && rst) begin
      if (mcyc < NB*C) begin
        smp = {smp[C-2:0], tx};
        if (busy) busy_cnt++;
        if (done) early_done = 1'b1;
        if (mcyc % C == C-1)
          check_val($sformatf("bit%0d", mcyc / C), 32'(smp), cur[mcyc / C] ? 32'hF : 32'h0);
        mcyc++;
      end else begin
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("busy_drop", 32'(busy), 32'd0);
        check_val("tx_idle", 32'(tx), 32'd1);
        check_val("busy_len", 32'(busy_cnt), 32'(NB*C));
        check_val("done_early", 32'(early_done), 32'd0);
        mon_act = 1'b0;
        last_done_ncyc = ncyc;
      end
    end
    prev_tx = tx;
  end

  task automatic send(input logic [7:0] d, input logic p);
    data_in = d;
    parity_in = p;
    load = 1'b1;
    sb_q.push_back(mk_frame(d, p));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < NB*C + 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tx", 32'(tx), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic frames
    send(8'hA5, 1'b0); exp_done_total++; wait_done();
    repeat (3) @(negedge clk);
    send(8'hA5, 1'b1); exp_done_total++; wait_done();
    repeat (2) @(negedge clk);
    send(8'h00, 1'b1); exp_done_total++; wait_done();
    repeat (2) @(negedge clk);

    // load held high; data changes mid-frame and is taken by the back-to-back frame
    data_in = 8'h3C; parity_in = 1'b0; load = 1'b1;
    sb_q.push_back(mk_frame(8'h3C, 1'b0)); exp_done_total++;
    repeat (10) @(negedge clk);
    data_in = 8'hFF;
    sb_q.push_back(mk_frame(8'hFF, 1'b0)); exp_done_total++;
    wait_done();
    @(negedge clk);
    load = 1'b0;
    wait_done();
    check_val("b2b_gap", 32'(last_gap), 32'd1);
    repeat (3) @(negedge clk);

    // data and a stray load while busy must not disturb the frame
    send(8'h96, 1'b1); exp_done_total++;
    repeat (8) @(negedge clk);
    data_in = 8'h69; parity_in = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    data_in = 8'hFF;
    wait_done();
    repeat (3) @(negedge clk);

    // asynchronous reset during data bit 3 aborts the frame
    send(8'h5A, 1'b0);
    repeat (17) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("abort_tx", 32'(tx), 32'd1);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("post_rst_tx", 32'(tx), 32'd1);
    send(8'h01, 1'b1); exp_done_total++; wait_done();
    repeat (5) @(negedge clk);

    check_val("done_count", 32'(done_cnt), 32'(exp_done_total));
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    check_val("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
